fifo_uart_drain: RTL
====================

# fifo_uart_drain

Drain controller sitting between the sniffer's register FIFO read port and the UART transmitter. It pops one word when the FIFO is non-empty and output is enabled, splits the word into bytes (MSB byte first), and hands each byte to the UART with a start/busy handshake. It is the only agent driving the FIFO read side. It sequences pop, capture and serialisation so that no word is lost or duplicated.

## Interface
Parameters:
- DATA_WIDTH, 16, FIFO word width; must be a multiple of 8, range 8..64; BYTES = DATA_WIDTH/8
- OVF_MARKER, 8'hA5, byte inserted after a FIFO overflow; used only with DRAIN_OVF_MARK_EN

Ports:
- clk  in  1  reference clock, shared with the FIFO and the UART
- rst  in  1  asynchronous, active-low reset
- enable  in  1  drain permitted; sampled only in IDLE
- fifo_rd_en  out  1  FIFO read enable, single-cycle pulse
- fifo_rd_DATA  in  DATA_WIDTH  FIFO output register, valid the cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty flag
- fifo_ovf  in  1  pulse: a write was attempted while the FIFO was full
- tx_DATA  out  8  byte to transmit, held stable from tx_start until tx_busy falls
- tx_start  out  1  single-cycle transmit request
- tx_busy  in  1  UART busy; rises the cycle after tx_start, falls when the byte is done
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, FETCH, LOAD, SEND, HOLD, WAIT, plus MARK when DRAIN_OVF_MARK_EN is defined.
- IDLE:
  - with the macro, ovf_pend && enable -> MARK;
  - else enable && !fifo_rd_empty -> FETCH;
  - else stay.
- FETCH: fifo_rd_en=1 for this cycle only -> LOAD.
- LOAD: shift_r <= fifo_rd_DATA; byte_cnt <= BYTES-1 -> SEND.
- SEND: if !tx_busy, then tx_DATA <= shift_r[DATA_WIDTH-1 -: 8] and tx_start=1 -> HOLD; else stay.
- HOLD: one cycle; tx_busy is ignored here -> WAIT.
- WAIT: when tx_busy=0:
  - if byte_cnt==0 -> IDLE;
  - else shift_r <= shift_r << 8, byte_cnt <= byte_cnt-1 -> SEND.
- MARK: if !tx_busy, then tx_DATA <= OVF_MARKER, tx_start=1, clear ovf_pend -> HOLD, and byte_cnt is forced to 0 so control returns to IDLE after the marker.
- byte_cnt width is clog2(BYTES), minimum 1 bit. Shifts are logical, with zero fill.
- enable is checked only in IDLE. Deasserting it mid-word completes the current word before stopping.
- fifo_rd_en is never asserted while fifo_rd_empty=1 and never asserted outside FETCH.

## Timing
- Reset values: fifo_rd_en=0, tx_start=0, tx_DATA=0, busy=0, state=IDLE, shift_r=0, byte_cnt=0, ovf_pend=0.
- Latency from the IDLE decision to the first tx_start is 3 cycles (FETCH, LOAD, SEND), given tx_busy=0.
- Minimum word period is BYTES*(3 + UART byte time) + 3 cycles. There is no back-to-back pop without passing through IDLE.
- Reset asserted mid-word: all state clears at once; the partially sent word is lost and the FIFO is not re-read.
- tx_busy already high on entry to SEND or MARK: the block waits; tx_start is never issued while tx_busy=1.

## Configuration
- DRAIN_OVF_MARK_EN defined:
  - A fifo_ovf pulse sets a sticky ovf_pend.
  - In IDLE, ovf_pend takes priority over FIFO data; one OVF_MARKER byte is sent, and it is sent even when the FIFO is empty.
  - If fifo_ovf and the clear happen in the same cycle, set wins: ovf_pend stays 1 and a second marker follows.
- DRAIN_OVF_MARK_EN undefined: fifo_ovf is ignored, there is no ovf_pend register and no MARK state, and OVF_MARKER is unused.

## Test plan
- Reset, with DATA_WIDTH=16, FIFO holding 16'h1234, enable=1, and a UART model with busy lasting 10 cycles -> exactly one fifo_rd_en pulse; bytes 8'h12 then 8'h34 are sent; busy returns to 0.
- FIFO preloaded with 3 words 16'hA1B2, 16'hC3D4, 16'hE5F6 -> 6 bytes in order A1 B2 C3 D4 E5 F6; 3 rd_en pulses; no rd_en while empty.
- enable dropped in the cycle after the first tx_start of word 16'h5566 -> both 55 and 66 are sent; no further rd_en although the FIFO is non-empty.
- tx_busy held high externally for 20 cycles before SEND -> tx_start is withheld until tx_busy=0, then a single pulse with stable tx_DATA.
- rst pulsed low in WAIT after byte 1 of 16'h7788 -> outputs return to reset values immediately; 8'h88 is never sent; the next word comes from the next FIFO entry.
- With DRAIN_OVF_MARK_EN, a fifo_ovf pulse while idle and the FIFO empty -> one byte 8'hA5 is sent; then 16'h0102 is written -> 01, 02 are sent. Without the macro -> no A5 byte.

Source files
------------

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - Pops FIFO words and serialises them MSB byte first onto a UART
//
// Optional feature macro: DRAIN_OVF_MARK_EN
//   When defined, a fifo_ovf pulse sets a sticky pending flag, and one
//   OVF_MARKER byte is sent from IDLE (ahead of FIFO data) to flag the loss.
//
// Parameters:
//   DATA_WIDTH  FIFO word width, multiple of 8 in 8..64
//   OVF_MARKER  byte sent after a FIFO overflow (macro builds only)
//
// Ports:
//   clk            reference clock shared with FIFO and UART
//   rst            asynchronous active-low reset
//   enable         drain permitted, sampled only in IDLE
//   fifo_rd_en     single-cycle FIFO read strobe (FETCH only)
//   fifo_rd_DATA   FIFO output word, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   fifo_ovf       FIFO overflow pulse
//   tx_DATA        byte to transmit, held from tx_start until tx_busy falls
//   tx_start       single-cycle transmit request
//   tx_busy        UART busy, rises the cycle after tx_start
//   busy           high whenever the controller is not in IDLE

module fifo_uart_drain #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] OVF_MARKER = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_DATA,
    input  logic                  fifo_rd_empty,
    input  logic                  fifo_ovf,
    output logic [7:0]            tx_DATA,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
`ifdef DRAIN_OVF_MARK_EN
    localparam logic [2:0] S_MARK  = 3'd6;
`endif

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      byte_cnt;

    // Decoded straight from the state register, so the read strobe can only
    // exist in FETCH, which is entered only when the FIFO reported data.
    assign fifo_rd_en = (state == S_FETCH);
    assign busy       = (state != S_IDLE);

`ifdef DRAIN_OVF_MARK_EN
    logic ovf_pend;

    // Set has priority over clear: an overflow landing in the same cycle as
    // the marker launch leaves the flag up so a second marker follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_pend <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_pend <= 1'b1;
        end else if (state == S_MARK && !tx_busy) begin
            ovf_pend <= 1'b0;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ^{fifo_ovf, OVF_MARKER};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            shift_r  <= '0;
            byte_cnt <= '0;
            tx_DATA  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef DRAIN_OVF_MARK_EN
                    if (ovf_pend && enable) begin
                        state <= S_MARK;
                    end else
`endif
                    if (enable && !fifo_rd_empty) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shift_r  <= fifo_rd_DATA;
                    byte_cnt <= CNT_W'(BYTES - 1);
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_DATA  <= shift_r[DATA_WIDTH-1 -: 8];
                        tx_start <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                // The UART only raises tx_busy the cycle after tx_start, so
                // its value here is stale and must not end the byte early.
                S_HOLD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (byte_cnt == '0) begin
                            state <= S_IDLE;
                        end else begin
                            shift_r  <= shift_r << 8;
                            byte_cnt <= byte_cnt - CNT_W'(1);
                            state    <= S_SEND;
                        end
                    end
                end
`ifdef DRAIN_OVF_MARK_EN
                // Zero count makes WAIT return to IDLE after the lone marker.
                S_MARK: begin
                    if (!tx_busy) begin
                        tx_DATA  <= OVF_MARKER;
                        tx_start <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
